// File: rtl/senha_pkg.sv
// Shared types and constants for the two-stage password game: controller states,
// comparator result codes and password widths.
package senha_pkg;

    typedef enum logic [2:0] {
        OCIOSO,
        ESPERA_A,
        COMPARA_A,
        ESPERA_B,
        COMPARA_B,
        ABERTO,
        BLOQUEADO
    } estado_t;

    localparam logic [1:0] RES_MENOR = 2'b00;
    localparam logic [1:0] RES_MAIOR = 2'b01;
    localparam logic [1:0] RES_IGUAL = 2'b10;

    localparam int SENHA_A_W = 4;
    localparam int SENHA_B_W = 3;

endpackage

// File: rtl/controle_jogo_senha_temporizador.sv
// Loadable lockout down-counter; fim pulses on the cycle before the count
// expires, so an FSM leaving on fim does so exactly CICLOS edges after carga.
module temporizador_bloqueio #(
    parameter int CICLOS = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic carga,
    output logic fim
);

    localparam int W = $clog2(CICLOS + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (carga) begin
            cnt_d = W'(CICLOS);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    assign fim = (cnt_q == W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/controle_jogo_senha.sv
// Sequencing controller for the two-stage password game (drives the external comparator).
// Optional lockout timer enabled by defining CONTROLE_SENHA_BLOQUEIO_EN.
module controle_jogo_senha
    import senha_pkg::*;
#(
    parameter int MAX_TENT    = 5,
    parameter int BLOQ_CICLOS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       iniciar,
    input  logic       confirma,
    input  logic [3:0] tentativa,
    input  logic [1:0] resultado,
    output logic [3:0] tentativa_a,
    output logic [2:0] tentativa_b,
    output logic       modo_b,
    output logic [1:0] dica,
    output logic       dica_valida,
    output logic [3:0] tentativas_rest,
    output logic       aberto,
    output logic       bloqueado
);

    localparam logic [3:0] RECARGA = 4'(MAX_TENT);

    if (MAX_TENT < 1 || MAX_TENT > 15) begin : g_chk_max_tent
        $error("MAX_TENT must be within 1..15");
    end
    if (BLOQ_CICLOS < 1) begin : g_chk_bloq
        $error("BLOQ_CICLOS must be at least 1");
    end

    estado_t                estado_q, estado_d;
    logic [SENHA_A_W-1:0]   tent_a_q, tent_a_d;
    logic [SENHA_B_W-1:0]   tent_b_q, tent_b_d;
    logic [1:0]             dica_q, dica_d;
    logic                   dica_valida_q, dica_valida_d;
    logic [3:0]             rest_q, rest_d;
    logic                   modo_b_q, modo_b_d;
    logic                   aberto_q, aberto_d;
    logic                   bloqueado_q, bloqueado_d;

`ifdef CONTROLE_SENHA_BLOQUEIO_EN
    logic fim_bloq;
    logic carga_bloq;

    assign carga_bloq = (estado_d == BLOQUEADO) && (estado_q != BLOQUEADO);

    temporizador_bloqueio #(
        .CICLOS(BLOQ_CICLOS)
    ) u_temporizador (
        .clk  (clk),
        .rst_n(rst_n),
        .carga(carga_bloq),
        .fim  (fim_bloq)
    );
`endif

    always_comb begin
        estado_d      = estado_q;
        tent_a_d      = tent_a_q;
        tent_b_d      = tent_b_q;
        dica_d        = dica_q;
        dica_valida_d = 1'b0;
        rest_d        = rest_q;

        if (iniciar) begin
            estado_d = ESPERA_A;
            rest_d   = RECARGA;
            dica_d   = '0;
        end else begin
            case (estado_q)
                ESPERA_A: begin
                    if (confirma) begin
                        tent_a_d = tentativa;
                        estado_d = COMPARA_A;
                    end
                end
                ESPERA_B: begin
                    if (confirma) begin
                        tent_b_d = tentativa[SENHA_B_W-1:0];
                        estado_d = COMPARA_B;
                    end
                end
                COMPARA_A, COMPARA_B: begin
                    dica_d        = resultado;
                    dica_valida_d = 1'b1;
                    if (resultado == RES_IGUAL) begin
                        estado_d = (estado_q == COMPARA_A) ? ESPERA_B : ABERTO;
                        rest_d   = RECARGA;
                    end else begin
                        // Saturating decrement; the last miss lands on 0 in BLOQUEADO.
                        rest_d = (rest_q != 4'd0) ? rest_q - 4'd1 : 4'd0;
                        if (rest_q <= 4'd1) begin
                            estado_d = BLOQUEADO;
                        end else begin
                            estado_d = (estado_q == COMPARA_A) ? ESPERA_A : ESPERA_B;
                        end
                    end
                end
                BLOQUEADO: begin
                    rest_d = '0;
`ifdef CONTROLE_SENHA_BLOQUEIO_EN
                    if (fim_bloq) begin
                        estado_d = OCIOSO;
                    end
`endif
                end
                default: ;
            endcase
        end

        modo_b_d    = (estado_d == ESPERA_B) || (estado_d == COMPARA_B) || (estado_d == ABERTO);
        aberto_d    = (estado_d == ABERTO);
        bloqueado_d = (estado_d == BLOQUEADO);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_q      <= OCIOSO;
            tent_a_q      <= '0;
            tent_b_q      <= '0;
            dica_q        <= '0;
            dica_valida_q <= 1'b0;
            rest_q        <= '0;
            modo_b_q      <= 1'b0;
            aberto_q      <= 1'b0;
            bloqueado_q   <= 1'b0;
        end else begin
            estado_q      <= estado_d;
            tent_a_q      <= tent_a_d;
            tent_b_q      <= tent_b_d;
            dica_q        <= dica_d;
            dica_valida_q <= dica_valida_d;
            rest_q        <= rest_d;
            modo_b_q      <= modo_b_d;
            aberto_q      <= aberto_d;
            bloqueado_q   <= bloqueado_d;
        end
    end

    assign tentativa_a     = tent_a_q;
    assign tentativa_b     = tent_b_q;
    assign modo_b          = modo_b_q;
    assign dica            = dica_q;
    assign dica_valida     = dica_valida_q;
    assign tentativas_rest = rest_q;
    assign aberto          = aberto_q;
    assign bloqueado       = bloqueado_q;

endmodule

// File: tb/tb_controle_jogo_senha.sv
// Self-checking bench for controle_jogo_senha with a behavioural game model and
// an in-bench comparator answering from secret passwords.
module tb_controle_jogo_senha;

    localparam int MAX_TENT = 5;
    localparam int BLOQ     = 16;

    localparam int P_IDLE = 0, P_AW = 1, P_AC = 2, P_BW = 3, P_BC = 4, P_OPEN = 5, P_LOCK = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       iniciar = 1'b0;
    logic       confirma = 1'b0;
    logic [3:0] tentativa = '0;
    logic [1:0] resultado;
    logic [3:0] tentativa_a;
    logic [2:0] tentativa_b;
    logic       modo_b;
    logic [1:0] dica;
    logic       dica_valida;
    logic [3:0] tentativas_rest;
    logic       aberto;
    logic       bloqueado;

    logic [3:0] sec_a = 4'd7;
    logic [2:0] sec_b = 3'd3;

    int n_chk = 0;
    int n_pass = 0;

    // Model state
    int         ph = P_IDLE;
    logic [3:0] m_ta = '0;
    logic [2:0] m_tb = '0;
    logic [1:0] m_dica = '0;
    logic       m_valid = 1'b0;
    int         m_rest = 0;
    int         m_lock = 0;

    always #5 clk = ~clk;

    function automatic logic [1:0] cmp(input logic [3:0] g, input logic [3:0] s);
        if (g < s) return 2'b00;
        if (g > s) return 2'b01;
        return 2'b10;
    endfunction

    assign resultado = modo_b ? cmp({1'b0, tentativa_b}, {1'b0, sec_b}) : cmp(tentativa_a, sec_a);

    controle_jogo_senha #(
        .MAX_TENT   (MAX_TENT),
        .BLOQ_CICLOS(BLOQ)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .iniciar        (iniciar),
        .confirma       (confirma),
        .tentativa      (tentativa),
        .resultado      (resultado),
        .tentativa_a    (tentativa_a),
        .tentativa_b    (tentativa_b),
        .modo_b         (modo_b),
        .dica           (dica),
        .dica_valida    (dica_valida),
        .tentativas_rest(tentativas_rest),
        .aberto         (aberto),
        .bloqueado      (bloqueado)
    );

    wire [16:0] dut_vec = {tentativa_a, tentativa_b, modo_b, dica, dica_valida,
                           tentativas_rest, aberto, bloqueado};

    function automatic logic [16:0] exp_vec();
        logic mb;
        mb = (ph == P_BW) || (ph == P_BC) || (ph == P_OPEN);
        return {m_ta, m_tb, mb, m_dica, m_valid, 4'(m_rest), ph == P_OPEN, ph == P_LOCK};
    endfunction

    task automatic model_step(input logic r, input logic ini, input logic conf, input logic [3:0] g);
        logic [1:0] res;
        m_valid = 1'b0;
        if (!r) begin
            ph = P_IDLE; m_ta = '0; m_tb = '0; m_dica = '0; m_rest = 0; m_lock = 0;
        end else if (ini) begin
            ph = P_AW; m_rest = MAX_TENT; m_dica = '0;
        end else begin
            case (ph)
                P_AW: if (conf) begin m_ta = g; ph = P_AC; end
                P_BW: if (conf) begin m_tb = g[2:0]; ph = P_BC; end
                P_AC, P_BC: begin
                    res = (ph == P_AC) ? cmp(m_ta, sec_a) : cmp({1'b0, m_tb}, {1'b0, sec_b});
                    m_dica  = res;
                    m_valid = 1'b1;
                    if (res == 2'b10) begin
                        m_rest = MAX_TENT;
                        ph = (ph == P_AC) ? P_BW : P_OPEN;
                    end else begin
                        m_rest = m_rest - 1;
                        if (m_rest == 0) begin
                            ph = P_LOCK; m_lock = BLOQ;
                        end else begin
                            ph = (ph == P_AC) ? P_AW : P_BW;
                        end
                    end
                end
                P_LOCK: begin
`ifdef CONTROLE_SENHA_BLOQUEIO_EN
                    m_lock = m_lock - 1;
                    if (m_lock == 0) ph = P_IDLE;
`endif
                end
                default: ;
            endcase
        end
    endtask

    // One clock: apply inputs, advance DUT and model, settle past the edge.
    task automatic cyc(input logic r, input logic ini, input logic conf, input logic [3:0] g);
        rst_n = r; iniciar = ini; confirma = conf; tentativa = g;
        @(posedge clk);
        model_step(r, ini, conf, g);
        #1;
    endtask

    task automatic test_reset();
        cyc(1'b0, 1'b0, 1'b0, 4'h0);
        cyc(1'b0, 1'b1, 1'b1, 4'hF);
        n_chk++;
        if (dut_vec !== 17'd0) $display("FAIL reset_outputs: got %h expected 0", dut_vec);
        else n_pass++;
        cyc(1'b1, 1'b0, 1'b1, 4'h5);
        n_chk++;
        if (dut_vec !== exp_vec()) $display("FAIL idle_ignores_confirma: got %h expected %h", dut_vec, exp_vec());
        else n_pass++;
    endtask

    task automatic test_stage_a();
        sec_a = 4'd7; sec_b = 3'd3;
        cyc(1'b1, 1'b1, 1'b0, 4'h0);
        n_chk++;
        if (tentativas_rest !== 4'd5 || modo_b !== 1'b0) $display("FAIL iniciar_load: got rest=%0d modo_b=%b expected 5/0", tentativas_rest, modo_b);
        else n_pass++;
        cyc(1'b1, 1'b0, 1'b1, 4'd7);
        n_chk++;
        if (tentativa_a !== 4'd7 || dica_valida !== 1'b0) $display("FAIL latch_a: got ta=%0d dv=%b expected 7/0", tentativa_a, dica_valida);
        else n_pass++;
        cyc(1'b1, 1'b0, 1'b1, 4'd2);
        n_chk++;
        if (dica !== 2'b10 || dica_valida !== 1'b1 || modo_b !== 1'b1 || tentativas_rest !== 4'd5)
            $display("FAIL match_a: got dica=%b dv=%b modo_b=%b rest=%0d expected 10/1/1/5", dica, dica_valida, modo_b, tentativas_rest);
        else n_pass++;
        cyc(1'b1, 1'b0, 1'b0, 4'd0);
        n_chk++;
        if (dut_vec !== exp_vec() || dica_valida !== 1'b0) $display("FAIL after_match_a: got %h expected %h", dut_vec, exp_vec());
        else n_pass++;
    endtask

    task automatic test_stage_b();
        cyc(1'b1, 1'b0, 1'b1, 4'b1011);
        n_chk++;
        if (tentativa_b !== 3'b011 || modo_b !== 1'b1) $display("FAIL latch_b: got tb=%b modo_b=%b expected 011/1", tentativa_b, modo_b);
        else n_pass++;
        cyc(1'b1, 1'b0, 1'b0, 4'd0);
        n_chk++;
        if (aberto !== 1'b1 || dica !== 2'b10 || dica_valida !== 1'b1) $display("FAIL open: got aberto=%b dica=%b dv=%b expected 1/10/1", aberto, dica, dica_valida);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 4'd1);
            n_chk++;
            if (dut_vec !== exp_vec() || aberto !== 1'b1 || tentativa_b !== 3'b011)
                $display("FAIL open_ignores_confirma: got %h expected %h", dut_vec, exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_lockout();
        logic [3:0] g;
        sec_a = 4'd7;
        cyc(1'b1, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < MAX_TENT; i++) begin
            g = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 6)) : 4'($urandom_range(8, 15));
            cyc(1'b1, 1'b0, 1'b1, g);
            cyc(1'b1, 1'b0, 1'b1, g);
            n_chk++;
            if (tentativas_rest !== 4'(MAX_TENT - 1 - i) || dica_valida !== 1'b1 || dica !== cmp(g, sec_a))
                $display("FAIL miss_count_%0d: got rest=%0d dv=%b dica=%b expected %0d/1/%b", i, tentativas_rest, dica_valida, dica, MAX_TENT - 1 - i, cmp(g, sec_a));
            else n_pass++;
        end
        n_chk++;
        if (bloqueado !== 1'b1 || modo_b !== 1'b0) $display("FAIL locked: got bloqueado=%b modo_b=%b expected 1/0", bloqueado, modo_b);
        else n_pass++;
    endtask

    task automatic test_lock_exit();
`ifdef CONTROLE_SENHA_BLOQUEIO_EN
        for (int k = 1; k <= BLOQ; k++) begin
            cyc(1'b1, 1'b0, 1'b1, 4'd7);
            n_chk++;
            if (bloqueado !== (k < BLOQ)) $display("FAIL lock_timer_%0d: got bloqueado=%b expected %b", k, bloqueado, k < BLOQ);
            else n_pass++;
        end
        cyc(1'b1, 1'b0, 1'b1, 4'd9);
        n_chk++;
        if (dut_vec !== exp_vec()) $display("FAIL idle_after_lock: got %h expected %h", dut_vec, exp_vec());
        else n_pass++;
`else
        for (int k = 0; k < 100; k++) cyc(1'b1, 1'b0, 1'b1, 4'd7);
        n_chk++;
        if (bloqueado !== 1'b1 || tentativas_rest !== 4'd0) $display("FAIL lock_holds: got bloqueado=%b rest=%0d expected 1/0", bloqueado, tentativas_rest);
        else n_pass++;
`endif
        cyc(1'b1, 1'b1, 1'b0, 4'd0);
        n_chk++;
        if (bloqueado !== 1'b0 || tentativas_rest !== 4'd5) $display("FAIL lock_iniciar: got bloqueado=%b rest=%0d expected 0/5", bloqueado, tentativas_rest);
        else n_pass++;
    endtask

    task automatic test_iniciar_priority();
        sec_a = 4'd7;
        cyc(1'b1, 1'b1, 1'b0, 4'd0);
        cyc(1'b1, 1'b0, 1'b1, 4'd7);
        cyc(1'b1, 1'b0, 1'b0, 4'd0);
        cyc(1'b1, 1'b1, 1'b1, 4'd3);
        n_chk++;
        if (modo_b !== 1'b0 || tentativas_rest !== 4'd5 || dica_valida !== 1'b0 || dica !== 2'b00)
            $display("FAIL iniciar_priority: got modo_b=%b rest=%0d dv=%b dica=%b expected 0/5/0/00", modo_b, tentativas_rest, dica_valida, dica);
        else n_pass++;
        cyc(1'b1, 1'b0, 1'b0, 4'd0);
        n_chk++;
        if (dut_vec !== exp_vec() || dica_valida !== 1'b0) $display("FAIL iniciar_no_hint: got %h expected %h", dut_vec, exp_vec());
        else n_pass++;
    endtask

    task automatic test_reset_mid_compare();
        cyc(1'b1, 1'b1, 1'b0, 4'd0);
        cyc(1'b1, 1'b0, 1'b1, 4'd2);
        cyc(1'b0, 1'b0, 1'b0, 4'd0);
        n_chk++;
        if (dut_vec !== 17'd0) $display("FAIL reset_mid_compare: got %h expected 0", dut_vec);
        else n_pass++;
        cyc(1'b1, 1'b0, 1'b0, 4'd0);
        n_chk++;
        if (dica_valida !== 1'b0 || dut_vec !== exp_vec()) $display("FAIL reset_no_hint: got %h expected %h", dut_vec, exp_vec());
        else n_pass++;
    endtask

    task automatic test_random();
        logic r, ini, conf;
        logic [3:0] g;
        sec_a = 4'($urandom_range(0, 15));
        sec_b = 3'($urandom_range(0, 7));
        cyc(1'b1, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 600; i++) begin
            r    = ($urandom_range(0, 79) != 0);
            ini  = ($urandom_range(0, 24) == 0);
            conf = ($urandom_range(0, 2) == 0);
            g    = ($urandom_range(0, 1) == 0) ? sec_a : 4'($urandom_range(0, 15));
            if (ph == P_BW && $urandom_range(0, 1) == 0) g = {1'($urandom_range(0, 1)), sec_b};
            cyc(r, ini, conf, g);
            n_chk++;
            if (dut_vec !== exp_vec()) $display("FAIL random_%0d: got %h expected %h", i, dut_vec, exp_vec());
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_stage_a();
        test_stage_b();
        test_lockout();
        test_lock_exit();
        test_iniciar_priority();
        test_reset_mid_compare();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
